// File: rtl/aes_shift_rows_pipe.sv
// aes_shift_rows_pipe
//   ShiftRows / InvShiftRows stage for Rijndael states of NB = 4, 6 or 8
//   columns. The direction is chosen per block. The result is held in a
//   2-entry output FIFO that has valid/ready handshakes on both sides.
//
// Ports
//   clk, rst_n           clock, async active-low reset
//   clr                  synchronous flush of the FIFO and the block counter
//   in_valid/in_ready    input handshake
//   in_inv               0 = ShiftRows, 1 = InvShiftRows (taken with the block)
//   in_state             byte (c,r) at bits [8*(4c+r) +: 8]
//   out_valid/out_ready  output handshake
//   out_state, out_inv   head entry: shifted state and echoed direction
//   blk_cnt              blocks accepted since reset/clr, wraps at 2^CNT_W
module aes_shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  input  logic [32*NB-1:0]  in_state,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NB-1:0]  out_state,
  output logic              out_inv,
  output logic [CNT_W-1:0]  blk_cnt
);

  localparam int W = 32 * NB;

  if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
    $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
  end

  // Row offsets: 0,1,2,3 for NB 4/6; 0,1,3,4 for NB 8.
  function automatic int shift_of(input int r);
    if (NB == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  logic [W-1:0] fwd_state;
  logic [W-1:0] inv_state;
  logic [W-1:0] shifted;

  // Both permutations are fixed wiring; only the final select costs logic.
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int S    = shift_of(r);
      localparam int SRCF = (c + S) % NB;
      localparam int SRCI = (c - S + NB) % NB;
      assign fwd_state[8*(4*c+r) +: 8] = in_state[8*(4*SRCF+r) +: 8];
      assign inv_state[8*(4*c+r) +: 8] = in_state[8*(4*SRCI+r) +: 8];
    end
  end

  assign shifted = in_inv ? inv_state : fwd_state;

  logic [W-1:0] mem_state [2];
  logic         mem_inv   [2];
  logic [1:0]   count;
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push;
  logic         pop;

  // in_ready depends only on state and clr, so out_ready has no
  // combinational path to it. A full FIFO cannot take a block in a pop cycle.
  assign in_ready  = (count != 2'd2) && !clr;
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_state = mem_state[rd_ptr];
  assign out_inv   = mem_inv[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      blk_cnt <= '0;
      for (int i = 0; i < 2; i++) begin
        mem_state[i] <= '0;
        mem_inv[i]   <= 1'b0;
      end
    end else if (clr) begin
      // Entries are left in place. The consumer still completes a pop that
      // happens in this cycle, and the head is stable until the next push.
      count   <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      blk_cnt <= '0;
    end else begin
      if (push) begin
        mem_state[wr_ptr] <= shifted;
        mem_inv[wr_ptr]   <= in_inv;
        wr_ptr            <= ~wr_ptr;
        blk_cnt           <= blk_cnt + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/aes_shift_rows_pipe.md
# aes_shift_rows_pipe

Pipelined, flow-controlled ShiftRows / InvShiftRows stage for the AES/Rijndael round datapath. It generalises the row-shift step to Rijndael block widths of 4, 6 or 8 columns, with the direction selectable per block. It registers results into a 2-entry output buffer behind valid/ready handshakes, so it can sit between SubBytes and MixColumns in a multi-cycle or pipelined round core.

## Interface
- NB, 4, number of state columns; legal values 4, 6, 8; any other value is an elaboration error
- CNT_W, 16, width of the accepted-block counter
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  reset, asynchronous assert, active-low
- clr  in  1  synchronous flush of the buffer and counter
- in_valid  in  1  input block present
- in_ready  out  1  block accepted when in_valid && in_ready
- in_inv  in  1  0 = ShiftRows, 1 = InvShiftRows; sampled with the block
- in_state  in  32*NB  state; byte (c,r) at bits [8*(4c+r)+7 : 8*(4c+r)]
- out_valid  out  1  head buffer entry valid
- out_ready  in  1  consumer takes the head when out_valid && out_ready
- out_state  out  32*NB  shifted state of the head entry, same byte layout
- out_inv  out  1  echo of in_inv for the head entry
- blk_cnt  out  CNT_W  number of blocks accepted since reset/clr, modulo 2^CNT_W

## Operation
- Shift offsets s_r per row r (0..3):
  - NB = 4 or 6: 0, 1, 2, 3
  - NB = 8: 0, 1, 3, 4
- Forward direction: out(c,r) = in((c + s_r) mod NB, r).
- Inverse direction: out(c,r) = in((c − s_r + NB) mod NB, r).
- Row 0 always passes through unchanged. A forward shift followed by an inverse shift returns the original state.
- The permutation is computed combinationally on in_state. The result and in_inv are written into the buffer on push.
- Buffer: 2-entry FIFO with a 2-bit count (0..2) and 1-bit read/write pointers.
  - push = in_valid && in_ready
  - pop = out_valid && out_ready
  - in_ready = (count != 2) && !clr, decoded from registers and clr only; no combinational path from out_ready.
  - out_valid = (count != 0). out_state and out_inv are driven from the head entry.
  - push and pop in the same cycle: count unchanged, order preserved.
  - At count == 2 a pop frees a slot only for the next cycle; there is no push in the same cycle.
- blk_cnt increments by 1 on every push and wraps from 2^CNT_W−1 to 0.
- clr (synchronous):
  - count, pointers and blk_cnt go to 0; out_valid drops on the next cycle.
  - A push in the same cycle is impossible because in_ready = 0.
  - A pop in the same cycle is still seen by the consumer as completed.
- Reset (rst_n low, asynchronous):
  - count = 0, pointers = 0, blk_cnt = 0, out_valid = 0, out_state = 0, out_inv = 0, in_ready = 1.
  - Buffer contents are cleared to 0, so out_state reads 0 when empty.
  - Reset mid-stream discards all buffered blocks without handshake.
- out_state/out_inv are undefined-but-stable when out_valid = 0, except after reset, where they are 0. They must not change while out_valid && !out_ready.

## Timing
- Latency 1 cycle: a block pushed at edge k is presented with out_valid = 1 after edge k.
- Throughput: 1 block/cycle sustained while out_ready = 1.
- Backpressure: with out_ready held 0, two blocks are accepted and in_ready falls after the second push edge.
- After out_ready returns, the head pops at the next edge and in_ready rises one cycle later.
- Data bus is stable under stall (AXI-stream-style rules). in_valid must not depend on in_ready.

## Test plan
- NB = 4, forward:
  - Stimulus: in_state bytes 0..15 = d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30, in_inv = 0.
  - Required: out bytes d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5, one cycle later.
- NB = 4, inverse: feed the previous output with in_inv = 1 → the original FIPS-197 bytes return, out_inv = 1.
- NB = 8, forward, byte i = i (0x00..0x1f):
  - Required: out(0,r) = in(0,0), in(1,1), in(3,2), in(4,3) = bytes 00, 05, 0e, 13.
  - Required: out(7,r) = 1c, 01, 0a, 0f.
  - Scoreboard all 32 bytes against a reference model; repeat for NB = 6.
- Backpressure:
  - Hold out_ready = 0 and drive 3 back-to-back valid blocks.
  - Required: 2 accepted, in_ready = 0 on the third, blk_cnt = 2.
  - Release out_ready: blocks emerge in order, and the third is accepted one cycle after the first pop.
- Random stall/valid traffic of 10,000 blocks with mixed in_inv:
  - No loss, duplication or reordering; data stable under stall.
  - blk_cnt = 10000 mod 2^CNT_W; force a wrap with CNT_W = 4.
- Assert clr, then rst_n, with count = 2:
  - Required: out_valid = 0 next cycle (immediately for rst_n), blk_cnt = 0, in_ready = 0 during clr and 1 after.
  - The following block passes with latency 1.
